// File: rtl/gelato_inst_ram_responder_pkg.sv
// Shared types and defaults for the instruction RAM responder.
package gelato_inst_ram_responder_pkg;

  localparam int INST_RAM_DEPTH_LOG2 = 12;

  typedef enum logic [1:0] {
    RAM_IDLE = 2'd0,
    RAM_WAIT = 2'd1,
    RAM_RESP = 2'd2
  } ram_resp_state_t;

endpackage

// File: rtl/gelato_inst_ram_responder_sync_ram.sv
// 1R1W synchronous word array; a read and a write to the same word in one cycle
// returns the old contents.
module gelato_sync_ram #(
  parameter int DEPTH_LOG2 = 12,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  i_clk,
  input  logic                  i_we,
  input  logic [DEPTH_LOG2-1:0] i_waddr,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  input  logic                  i_re,
  input  logic [DEPTH_LOG2-1:0] i_raddr,
  output logic [DATA_WIDTH-1:0] o_rdata
);

  logic [DATA_WIDTH-1:0] r_mem [1 << DEPTH_LOG2];
  logic [DATA_WIDTH-1:0] r_rdata;

  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
    if (i_re) begin
      r_rdata <= r_mem[i_raddr];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/gelato_inst_ram_responder.sv
// Instruction-fetch slave: latches a request, waits LATENCY rdy-qualified cycles,
// then returns one word from the preloadable instruction array with a done pulse.
module gelato_inst_ram_responder
  import gelato_inst_ram_responder_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH_LOG2 = INST_RAM_DEPTH_LOG2,
  parameter int LATENCY    = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_rdy,
  input  logic                  i_fetch_valid,
  input  logic [ADDR_WIDTH-1:0] i_fetch_addr,
  output logic                  o_fetch_done,
  output logic [DATA_WIDTH-1:0] o_fetch_data,
  input  logic                  i_init_we,
  input  logic [ADDR_WIDTH-1:0] i_init_addr,
  input  logic [DATA_WIDTH-1:0] i_init_data,
  output logic                  o_busy
);

  if (LATENCY < 1 || LATENCY > 255) begin : g_bad_latency
    $error("gelato_inst_ram_responder: LATENCY must be in 1..255");
  end

  localparam logic [7:0]            CNT_LOAD  = 8'(LATENCY - 1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_LIMIT = ADDR_WIDTH'(64'd4 << DEPTH_LOG2);

  ram_resp_state_t r_state;
  ram_resp_state_t w_next_state;
  logic [7:0]            r_cnt;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic                  r_rd_zero;

  logic [ADDR_WIDTH-1:0] w_rd_addr;
  logic                  w_rd_in_range;
  logic                  w_wr_en;
  logic                  w_resp_entry;
  logic [DATA_WIDTH-1:0] w_ram_rdata;

  // With LATENCY==1 the read fires on the acceptance edge, before r_addr holds the address.
  assign w_rd_addr     = (r_state == RAM_IDLE) ? i_fetch_addr : r_addr;
  assign w_rd_in_range = (w_rd_addr < ADDR_LIMIT);
  assign w_wr_en       = i_init_we && (i_init_addr < ADDR_LIMIT);
  assign w_resp_entry  = (w_next_state == RAM_RESP) && (r_state != RAM_RESP);

  gelato_sync_ram #(
    .DEPTH_LOG2 (DEPTH_LOG2),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_ram (
    .i_clk   (i_clk),
    .i_we    (w_wr_en),
    .i_waddr (i_init_addr[DEPTH_LOG2+1:2]),
    .i_wdata (i_init_data),
    .i_re    (w_resp_entry),
    .i_raddr (w_rd_addr[DEPTH_LOG2+1:2]),
    .o_rdata (w_ram_rdata)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= RAM_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      RAM_IDLE: begin
        if (i_fetch_valid) begin
          w_next_state = (LATENCY == 1) ? RAM_RESP : RAM_WAIT;
        end
      end
      RAM_WAIT: begin
        if (i_rdy && (r_cnt == 8'd1)) begin
          w_next_state = RAM_RESP;
        end
      end
      RAM_RESP: w_next_state = RAM_IDLE;
      default:  w_next_state = RAM_IDLE;
    endcase
  end

  // r_rd_zero masks the uninitialised RAM output after reset and blanks out-of-range reads.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt     <= '0;
      r_addr    <= '0;
      r_rd_zero <= 1'b1;
    end else begin
      if ((r_state == RAM_IDLE) && i_fetch_valid) begin
        r_addr <= i_fetch_addr;
        r_cnt  <= CNT_LOAD;
      end else if ((r_state == RAM_WAIT) && i_rdy) begin
        r_cnt <= r_cnt - 8'd1;
      end
      if (w_resp_entry) begin
        r_rd_zero <= !w_rd_in_range;
      end
    end
  end

  assign o_fetch_data = r_rd_zero ? '0 : w_ram_rdata;
  assign o_fetch_done = (r_state == RAM_RESP);
  assign o_busy       = (r_state != RAM_IDLE);

endmodule

// File: tb/tb_gelato_inst_ram_responder.sv
// Directed bench: one LATENCY=4 responder and one LATENCY=1 responder sharing
// clock, reset, rdy, address and preload port.
module tb_gelato_inst_ram_responder;

  logic        clk;
  logic        rstN;
  logic        rdy;
  logic        valid4;
  logic        valid1;
  logic [31:0] fetchAddr;
  logic        initWe;
  logic [31:0] initAddr;
  logic [31:0] initData;
  logic        done4;
  logic [31:0] data4;
  logic        busy4;
  logic        done1;
  logic [31:0] data1;
  logic        busy1;

  int testCount = 0;
  int failCount = 0;

  gelato_inst_ram_responder #(.LATENCY(4)) dut4 (
    .i_clk         (clk),
    .i_rst_n       (rstN),
    .i_rdy         (rdy),
    .i_fetch_valid (valid4),
    .i_fetch_addr  (fetchAddr),
    .o_fetch_done  (done4),
    .o_fetch_data  (data4),
    .i_init_we     (initWe),
    .i_init_addr   (initAddr),
    .i_init_data   (initData),
    .o_busy        (busy4)
  );

  gelato_inst_ram_responder #(.LATENCY(1)) dut1 (
    .i_clk         (clk),
    .i_rst_n       (rstN),
    .i_rdy         (rdy),
    .i_fetch_valid (valid1),
    .i_fetch_addr  (fetchAddr),
    .o_fetch_done  (done1),
    .o_fetch_data  (data1),
    .i_init_we     (initWe),
    .i_init_addr   (initAddr),
    .i_init_data   (initData),
    .o_busy        (busy1)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    testCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
    end
  endtask

  task automatic preload(input logic [31:0] a, input logic [31:0] d);
    initAddr = a;
    initData = d;
    initWe   = 1'b1;
    tick();
    initWe   = 1'b0;
  endtask

  // One request on the LATENCY=4 responder; cycle 1 is the first cycle after acceptance.
  task automatic applyStimulus(input string tag, input logic [31:0] a,
                               input logic [31:0] midAddr, input int stallFrom,
                               input int stallLen, input int wrCycle,
                               input logic [31:0] wrData, input logic rdyInResp,
                               input logic [31:0] expData, input int expCycle);
    int          doneAt;
    int          busyLow;
    logic [31:0] got;
    doneAt    = -1;
    busyLow   = 0;
    got       = '0;
    fetchAddr = a;
    valid4    = 1'b1;
    rdy       = 1'b1;
    tick();
    for (int c = 1; c <= 40 && doneAt < 0; c++) begin
      if (!busy4) busyLow++;
      if (done4) begin
        doneAt = c;
        got    = data4;
      end else begin
        if (c == 2) fetchAddr = midAddr;
        rdy      = (c >= stallFrom && c < stallFrom + stallLen) ? 1'b0 : 1'b1;
        initWe   = (c == wrCycle);
        initAddr = a;
        initData = wrData;
        tick();
      end
    end
    initWe = 1'b0;
    checkOutput({tag, " done cycle"}, doneAt, expCycle);
    checkOutput({tag, " data"}, got, expData);
    checkOutput({tag, " busy while pending"}, busyLow, 0);
    valid4 = 1'b0;
    rdy    = rdyInResp;
    tick();
    checkOutput({tag, " done falls"}, {31'b0, done4}, 32'd0);
    checkOutput({tag, " busy falls"}, {31'b0, busy4}, 32'd0);
    checkOutput({tag, " data held"}, data4, expData);
    rdy = 1'b1;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int doneSeen;
    clk       = 1'b0;
    rstN      = 1'b1;
    rdy       = 1'b1;
    valid4    = 1'b0;
    valid1    = 1'b0;
    fetchAddr = '0;
    initWe    = 1'b0;
    initAddr  = '0;
    initData  = '0;

    #2 rstN = 1'b0;
    #2;
    checkOutput("reset done", {31'b0, done4}, 32'd0);
    checkOutput("reset data", data4, 32'd0);
    checkOutput("reset busy", {31'b0, busy4}, 32'd0);
    checkOutput("reset done lat1", {31'b0, done1}, 32'd0);
    tick();
    tick();
    rstN = 1'b1;
    tick();
    tick();
    tick();
    checkOutput("idle done", {31'b0, done4}, 32'd0);
    checkOutput("idle data", data4, 32'd0);
    checkOutput("idle busy", {31'b0, busy4}, 32'd0);

    preload(32'h0000_0100, 32'hDEAD_BEEF);
    preload(32'h0000_0000, 32'h0000_0011);
    preload(32'h0000_0004, 32'h0000_0022);
    preload(32'h0000_3FFC, 32'hCAFE_F00D);
    preload(32'h0000_0200, 32'h2002_0000);
    preload(32'h0000_4000, 32'h9999_9999);

    applyStimulus("single", 32'h100, 32'h100, 0, 0, 0, 32'h0, 1'b1, 32'hDEAD_BEEF, 4);
    applyStimulus("stall", 32'h100, 32'h100, 2, 3, 0, 32'h0, 1'b0, 32'hDEAD_BEEF, 7);

    fetchAddr = 32'h0;
    valid1    = 1'b1;
    tick();
    checkOutput("b2b first done", {31'b0, done1}, 32'd1);
    checkOutput("b2b first data", data1, 32'h11);
    fetchAddr = 32'h4;
    tick();
    checkOutput("b2b gap done", {31'b0, done1}, 32'd0);
    checkOutput("b2b gap busy", {31'b0, busy1}, 32'd0);
    tick();
    checkOutput("b2b second done", {31'b0, done1}, 32'd1);
    checkOutput("b2b second data", data1, 32'h22);
    valid1 = 1'b0;
    tick();
    checkOutput("b2b after done", {31'b0, done1}, 32'd0);

    applyStimulus("last word", 32'h3FFC, 32'h3FFC, 0, 0, 0, 32'h0, 1'b1, 32'hCAFE_F00D, 4);
    applyStimulus("out of range", 32'h4000, 32'h4000, 0, 0, 0, 32'h0, 1'b1, 32'h0, 4);
    applyStimulus("unaligned", 32'h102, 32'h102, 0, 0, 0, 32'h0, 1'b1, 32'hDEAD_BEEF, 4);
    applyStimulus("addr change", 32'h100, 32'h200, 0, 0, 0, 32'h0, 1'b1, 32'hDEAD_BEEF, 4);

    applyStimulus("rbw old", 32'h100, 32'h100, 0, 0, 3, 32'h55, 1'b1, 32'hDEAD_BEEF, 4);
    applyStimulus("rbw new", 32'h100, 32'h100, 0, 0, 0, 32'h0, 1'b1, 32'h55, 4);
    applyStimulus("early write", 32'h100, 32'h100, 0, 0, 2, 32'h66, 1'b1, 32'h66, 4);

    fetchAddr = 32'h100;
    valid4    = 1'b1;
    tick();
    tick();
    checkOutput("abort busy before", {31'b0, busy4}, 32'd1);
    valid4 = 1'b0;
    rstN   = 1'b0;
    #1;
    checkOutput("abort busy", {31'b0, busy4}, 32'd0);
    checkOutput("abort done", {31'b0, done4}, 32'd0);
    checkOutput("abort data", data4, 32'd0);
    tick();
    rstN     = 1'b1;
    doneSeen = 0;
    for (int c = 0; c < 8; c++) begin
      tick();
      if (done4) doneSeen++;
    end
    checkOutput("abort no done", doneSeen, 0);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
